// File: rtl/rns_pkg.sv
// Shared types and constants for the RNS modulo reducer: FSM state encoding,
// default widths and the step-counter width helper.
package rns_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DEF_DIVIDEND_W = 8;
    localparam int DEF_MOD_W      = 4;

    // ceil(log2(w)), kept at least 1 so the step counter always has a bit.
    function automatic int step_cnt_w(input int w);
        return (w <= 2) ? 1 : $clog2(w);
    endfunction

endpackage

// File: rtl/rns_cond_sub.sv
// One restoring-division step: compare residue with m << k at full width and
// subtract when it fits. Purely combinational.
module rns_cond_sub #(
    parameter int DIVIDEND_W = 8,
    parameter int MOD_W      = 4,
    parameter int K_W        = 3
) (
    input  logic [DIVIDEND_W-1:0] i_r,
    input  logic [MOD_W-1:0]      i_m,
    input  logic [K_W-1:0]        i_k,
    output logic [DIVIDEND_W-1:0] o_r,
    output logic                  o_sub
);
    localparam int S_W = DIVIDEND_W + MOD_W - 1;

    logic [S_W-1:0] w_s;
    logic [S_W-1:0] w_r_ext;

    assign w_s     = S_W'(i_m) << i_k;
    assign w_r_ext = S_W'(i_r);
    assign o_sub   = (w_r_ext >= w_s);
    // When the subtract happens the difference fits in DIVIDEND_W bits, so the
    // low bits of s are all that matter for the result.
    assign o_r     = o_sub ? (i_r - w_s[DIVIDEND_W-1:0]) : i_r;

endmodule

// File: rtl/rns_mod_reduce_seq.sv
// Sequential remainder = dividend mod modulus, one shift/compare/subtract per clock.
// Optional quotient output when RNS_MOD_QUOTIENT_EN is defined.
module rns_mod_reduce_seq
    import rns_pkg::*;
#(
    parameter int DIVIDEND_W = DEF_DIVIDEND_W,
    parameter int MOD_W      = DEF_MOD_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DIVIDEND_W-1:0] dividend,
    input  logic [MOD_W-1:0]      modulus,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [MOD_W-1:0]      remainder,
    output logic                  mod_err
`ifdef RNS_MOD_QUOTIENT_EN
    ,
    output logic [DIVIDEND_W-1:0] quotient
`endif
);
    localparam int             K_W   = step_cnt_w(DIVIDEND_W);
    localparam logic [K_W-1:0] K_MAX = K_W'(DIVIDEND_W - 1);

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [DIVIDEND_W-1:0]   r_res;
    logic [DIVIDEND_W-1:0]   w_res_nxt;
    logic [MOD_W-1:0]        r_mod;
    logic [K_W-1:0]          r_k;
    logic                    r_err;
    logic                    w_sub;
    logic                    w_accept;
    logic                    w_mod_zero;

    assign w_mod_zero = (modulus == '0);

    rns_cond_sub #(
        .DIVIDEND_W (DIVIDEND_W),
        .MOD_W      (MOD_W),
        .K_W        (K_W)
    ) u_cond_sub (
        .i_r   (r_res),
        .i_m   (r_mod),
        .i_k   (r_k),
        .o_r   (w_res_nxt),
        .o_sub (w_sub)
    );

    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        w_accept    = 1'b0;
        case (r_state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_accept    = 1'b1;
                    w_state_nxt = w_mod_zero ? DONE : RUN;
                end
            end
            RUN: begin
                if (r_k == '0) begin
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
        remainder = out_valid ? r_res[MOD_W-1:0] : '0;
    end

    assign mod_err = r_err;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // A zero modulus loads a zero residue so the forced remainder falls out naturally.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_res <= '0;
            r_mod <= '0;
            r_k   <= '0;
            r_err <= 1'b0;
        end else if (w_accept) begin
            r_res <= w_mod_zero ? '0 : dividend;
            r_mod <= modulus;
            r_k   <= K_MAX;
            r_err <= w_mod_zero;
        end else if (r_state == RUN) begin
            r_res <= w_res_nxt;
            if (r_k != '0) begin
                r_k <= r_k - 1'b1;
            end
        end
    end

`ifdef RNS_MOD_QUOTIENT_EN
    logic [DIVIDEND_W-1:0] r_quo;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_quo <= '0;
        end else if (w_accept) begin
            r_quo <= '0;
        end else if (r_state == RUN && w_sub) begin
            r_quo[r_k] <= 1'b1;
        end
    end

    assign quotient = r_quo;
`endif

endmodule

// File: tb/tb_rns_mod_reduce_seq.sv
// Directed bench for rns_mod_reduce_seq at 8/4, plus 4/3 exhaustive and 16/8 spot checks.
module tb_rns_mod_reduce_seq;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // ---- 8/4 instance
    logic       v0 = 1'b0, rdy0, ov0, or0 = 1'b0, err0;
    logic [7:0] a0 = '0;
    logic [3:0] m0 = '0, rem0;
    // ---- 4/3 instance
    logic       v1 = 1'b0, rdy1, ov1, or1 = 1'b0, err1;
    logic [3:0] a1 = '0;
    logic [2:0] m1 = '0, rem1;
    // ---- 16/8 instance
    logic        v2 = 1'b0, rdy2, ov2, or2 = 1'b0, err2;
    logic [15:0] a2 = '0;
    logic [7:0]  m2 = '0, rem2;
`ifdef RNS_MOD_QUOTIENT_EN
    logic [7:0]  quo0;
    logic [3:0]  quo1;
    logic [15:0] quo2;
`endif

    rns_mod_reduce_seq #(.DIVIDEND_W(8), .MOD_W(4)) dut0 (
        .clk(clk), .rst(rst), .in_valid(v0), .in_ready(rdy0), .dividend(a0), .modulus(m0),
        .out_valid(ov0), .out_ready(or0), .remainder(rem0), .mod_err(err0)
`ifdef RNS_MOD_QUOTIENT_EN
        , .quotient(quo0)
`endif
    );

    rns_mod_reduce_seq #(.DIVIDEND_W(4), .MOD_W(3)) dut1 (
        .clk(clk), .rst(rst), .in_valid(v1), .in_ready(rdy1), .dividend(a1), .modulus(m1),
        .out_valid(ov1), .out_ready(or1), .remainder(rem1), .mod_err(err1)
`ifdef RNS_MOD_QUOTIENT_EN
        , .quotient(quo1)
`endif
    );

    rns_mod_reduce_seq #(.DIVIDEND_W(16), .MOD_W(8)) dut2 (
        .clk(clk), .rst(rst), .in_valid(v2), .in_ready(rdy2), .dividend(a2), .modulus(m2),
        .out_valid(ov2), .out_ready(or2), .remainder(rem2), .mod_err(err2)
`ifdef RNS_MOD_QUOTIENT_EN
        , .quotient(quo2)
`endif
    );

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Latency is counted in clock edges after the acceptance edge until out_valid is seen.
    task automatic op0(input logic [7:0] a, input logic [3:0] m, input int exp_lat,
                       input logic [3:0] er, input logic ee, input logic [7:0] eq, input int hold);
        int lat;
        @(negedge clk);
        check_val("op0_in_ready", rdy0, 1);
        a0 = a; m0 = m; v0 = 1'b1;
        @(posedge clk);
        #1;
        v0 = 1'b0; a0 = 8'hA5; m0 = 4'h3;
        lat = 0;
        while (!ov0 && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check_val("op0_latency", lat, exp_lat);
        check_val("op0_remainder", rem0, er);
        check_val("op0_mod_err", err0, ee);
`ifdef RNS_MOD_QUOTIENT_EN
        check_val("op0_quotient", quo0, eq);
`else
        if (eq != eq) check_val("op0_quotient_unused", 0, 1);
`endif
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            v0 = 1'b1; a0 = 8'd3; m0 = 4'd2;
            @(posedge clk);
            #1;
            v0 = 1'b0;
            check_val("hold_out_valid", ov0, 1);
            check_val("hold_in_ready", rdy0, 0);
            check_val("hold_remainder", rem0, er);
            check_val("hold_mod_err", err0, ee);
        end
        @(negedge clk);
        or0 = 1'b1;
        @(posedge clk);
        #1;
        or0 = 1'b0;
        check_val("release_out_valid", ov0, 0);
        check_val("release_in_ready", rdy0, 1);
    endtask

    task automatic op1(input logic [3:0] a, input logic [2:0] m);
        int lat;
        @(negedge clk);
        a1 = a; m1 = m; v1 = 1'b1;
        @(posedge clk);
        #1;
        v1 = 1'b0;
        lat = 0;
        while (!ov1 && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check_val("w4_latency", lat, (m == 0) ? 0 : 4);
        check_val("w4_remainder", rem1, (m == 0) ? 0 : int'(a) % int'(m));
        check_val("w4_mod_err", err1, (m == 0) ? 1 : 0);
`ifdef RNS_MOD_QUOTIENT_EN
        check_val("w4_quotient", quo1, (m == 0) ? 0 : int'(a) / int'(m));
`endif
        @(negedge clk);
        or1 = 1'b1;
        @(posedge clk);
        #1;
        or1 = 1'b0;
    endtask

    task automatic op2(input logic [15:0] a, input logic [7:0] m, input logic [7:0] er, input logic [15:0] eq);
        int lat;
        @(negedge clk);
        a2 = a; m2 = m; v2 = 1'b1;
        @(posedge clk);
        #1;
        v2 = 1'b0;
        lat = 0;
        while (!ov2 && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check_val("w16_latency", lat, (m == 0) ? 0 : 16);
        check_val("w16_remainder", rem2, er);
        check_val("w16_mod_err", err2, (m == 0) ? 1 : 0);
`ifdef RNS_MOD_QUOTIENT_EN
        check_val("w16_quotient", quo2, eq);
`else
        if (eq != eq) check_val("w16_quotient_unused", 0, 1);
`endif
        @(negedge clk);
        or2 = 1'b1;
        @(posedge clk);
        #1;
        or2 = 1'b0;
    endtask

    initial begin
        #2;
        check_val("rst_in_ready", rdy0, 1);
        check_val("rst_out_valid", ov0, 0);
        check_val("rst_remainder", rem0, 0);
        check_val("rst_mod_err", err0, 0);
`ifdef RNS_MOD_QUOTIENT_EN
        check_val("rst_quotient", quo0, 0);
`endif
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        op0(8'd200, 4'd7,  8, 4'd4,  1'b0, 8'd28,  0);
        op0(8'd13,  4'd15, 8, 4'd13, 1'b0, 8'd0,   0);
        op0(8'd255, 4'd1,  8, 4'd0,  1'b0, 8'd255, 0);
        op0(8'd255, 4'd15, 8, 4'd0,  1'b0, 8'd17,  0);
        op0(8'd0,   4'd5,  8, 4'd0,  1'b0, 8'd0,   0);
        op0(8'd5,   4'd5,  8, 4'd0,  1'b0, 8'd1,   0);
        op0(8'd99,  4'd0,  0, 4'd0,  1'b1, 8'd0,   0);
        op0(8'd200, 4'd7,  8, 4'd4,  1'b0, 8'd28,  5);

        // Reset asynchronously in the middle of the fourth RUN step.
        @(negedge clk);
        a0 = 8'd200; m0 = 4'd7; v0 = 1'b1;
        @(posedge clk);
        #1;
        v0 = 1'b0;
        repeat (3) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check_val("midrst_in_ready", rdy0, 1);
        check_val("midrst_out_valid", ov0, 0);
        check_val("midrst_remainder", rem0, 0);
        check_val("midrst_mod_err", err0, 0);
`ifdef RNS_MOD_QUOTIENT_EN
        check_val("midrst_quotient", quo0, 0);
`endif
        @(negedge clk);
        rst = 1'b0;
        op0(8'd100, 4'd9, 8, 4'd1, 1'b0, 8'd11, 0);

        for (int a = 0; a < 16; a++) begin
            for (int m = 0; m < 8; m++) begin
                op1(a[3:0], m[2:0]);
            end
        end

        op2(16'd65535, 8'd255, 8'd0,  16'd257);
        op2(16'd65535, 8'd254, 8'd3,  16'd258);
        op2(16'd50000, 8'd251, 8'd51, 16'd199);
        op2(16'd1234,  8'd200, 8'd34, 16'd6);
        op2(16'd300,   8'd0,   8'd0,  16'd0);
        for (int i = 0; i < 8; i++) begin
            logic [15:0] ra;
            logic [7:0]  rm;
            ra = 16'($urandom);
            rm = 8'($urandom_range(1, 255));
            op2(ra, rm, 8'(ra % 16'(rm)), ra / 16'(rm));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
